// File: rtl/display_scanner.sv
// Row-multiplexed 16x16 LED matrix scanner: snapshot frame, then blank/show each row in turn.
// Optional macro SCAN_DIMMING_EN adds a 4-bit Brightness input and per-row PWM on ColData.
module display_scanner #(
  parameter int ROW_CYCLES   = 1024,
  parameter int BLANK_CYCLES = 4
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic [255:0] DisplayBuffer,
`ifdef SCAN_DIMMING_EN
  input  logic [3:0]   Brightness,
`endif
  output logic [15:0]  RowSel,
  output logic [15:0]  ColData,
  output logic         FrameStart
);

  localparam int MAX_CYCLES = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    LATCH = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t             r_state;
  logic [3:0]         r_row;
  logic [CNT_W-1:0]   r_cnt;
  logic [255:0]       r_frame;
  logic [15:0]        r_rowSel;
  logic [15:0]        r_colData;
  logic               r_frameStart;
`ifdef SCAN_DIMMING_EN
  logic [3:0]         r_bright;
  logic [3:0]         r_pwm;
`endif

  logic [15:0]        w_rowData;
  logic [15:0]        w_colNext;
  logic               w_blankDone;
  logic               w_showDone;

  assign w_rowData   = r_frame[{r_row, 4'h0} +: 16];
  assign w_blankDone = (r_cnt == CNT_W'(BLANK_CYCLES - 1));
  assign w_showDone  = (r_cnt == CNT_W'(ROW_CYCLES - 1));

`ifdef SCAN_DIMMING_EN
  // Columns are gated off once the PWM count passes the latched brightness; rows stay driven.
  assign w_colNext = (r_pwm <= r_bright) ? w_rowData : 16'h0000;
`else
  assign w_colNext = w_rowData;
`endif

  assign RowSel     = r_rowSel;
  assign ColData    = r_colData;
  assign FrameStart = r_frameStart;

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state      <= LATCH;
      r_row        <= 4'd0;
      r_cnt        <= '0;
      r_frame      <= '0;
      r_rowSel     <= 16'h0000;
      r_colData    <= 16'h0000;
      r_frameStart <= 1'b0;
`ifdef SCAN_DIMMING_EN
      r_bright     <= 4'd0;
      r_pwm        <= 4'd0;
`endif
    end else begin
      case (r_state)
        LATCH: begin
          r_frame      <= DisplayBuffer;
          r_row        <= 4'd0;
          r_cnt        <= '0;
          r_rowSel     <= 16'h0000;
          r_colData    <= 16'h0000;
          r_frameStart <= 1'b1;
`ifdef SCAN_DIMMING_EN
          r_bright     <= Brightness;
`endif
          r_state      <= BLANK;
        end

        BLANK: begin
          r_rowSel     <= 16'h0000;
          r_colData    <= 16'h0000;
          r_frameStart <= 1'b0;
          if (w_blankDone) begin
            r_cnt   <= '0;
`ifdef SCAN_DIMMING_EN
            r_pwm   <= 4'd0;
`endif
            r_state <= SHOW;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        SHOW: begin
          r_rowSel     <= 16'h0001 << r_row;
          r_colData    <= w_colNext;
          r_frameStart <= 1'b0;
`ifdef SCAN_DIMMING_EN
          r_pwm        <= r_pwm + 4'd1;
`endif
          // The row index only advances after its last SHOW cycle has been driven.
          if (w_showDone) begin
            r_cnt <= '0;
            if (r_row == 4'd15) begin
              r_state <= LATCH;
            end else begin
              r_row   <= r_row + 4'd1;
              r_state <= BLANK;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_rowSel     <= 16'h0000;
          r_colData    <= 16'h0000;
          r_frameStart <= 1'b0;
          r_cnt        <= '0;
          r_state      <= LATCH;
        end
      endcase
    end
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter ROW_CYCLES, default 1024: cycles each row is driven (SHOW phase), legal range >= 1.
REQ-002 Parameter BLANK_CYCLES, default 4: anti-ghost blanking cycles before each row, legal range >= 1.
REQ-003 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port RESET  input  1  synchronous, active-high reset.
REQ-005 Port DisplayBuffer  input  256  frame from Processor; row r = bits [16r+15:16r], column c = bit c of that row.
REQ-006 Port RowSel  output  16  one-hot active-high row drive, registered.
REQ-007 Port ColData  output  16  active-high column drive, registered.
REQ-008 Port FrameStart  output  1  one-cycle pulse marking snapshot of a new frame, registered.

Function
REQ-009 The block SHALL implement states LATCH, BLANK, SHOW, plus a 4-bit row counter and a phase cycle counter.
REQ-010 LATCH SHALL last exactly 1 cycle: copy DisplayBuffer into an internal 256-bit frame register, row <= 0, FrameStart = 1, RowSel = 0, ColData = 0, next state BLANK.
REQ-011 BLANK SHALL last exactly BLANK_CYCLES cycles with RowSel = 0, ColData = 0, FrameStart = 0, then go to SHOW.
REQ-012 SHOW SHALL last exactly ROW_CYCLES cycles with RowSel = 16'h0001 << row and ColData = frame register row [row].
REQ-013 At the end of SHOW with row < 15, the block SHALL increment row and go to BLANK; with row = 15, it SHALL go to LATCH (row wraps to 0 there).
REQ-014 Frame period SHALL be exactly 1 + 16*(BLANK_CYCLES + ROW_CYCLES) cycles; defaults give 16449.
REQ-015 Changes on DisplayBuffer outside the LATCH cycle SHALL NOT affect outputs until the next LATCH (tear-free).
REQ-016 RowSel SHALL never have more than one bit set; RowSel = 0 implies ColData = 0.
REQ-017 The phase counter SHALL clear on every state transition; no counter may wrap silently within a phase.

Reset
REQ-018 While RESET = 1 at a rising edge: state <= LATCH, row <= 0, counters <= 0, RowSel <= 0, ColData <= 0, FrameStart <= 0, frame register <= 0.
REQ-019 The first rising edge with RESET = 0 SHALL execute LATCH (FrameStart = 1 in the following cycle).
REQ-020 RESET asserted mid-frame (any state, any row) SHALL zero all outputs at the next edge and abandon the frame; after release, scanning restarts at row 0 with a fresh snapshot.

Configuration
REQ-021 Macro SCAN_DIMMING_EN: when defined, the block adds input port Brightness (4 bits), sampled in LATCH, and a 4-bit PWM counter cleared on SHOW entry and incremented every SHOW cycle (wraps mod 16).
REQ-022 With SCAN_DIMMING_EN defined, ColData SHALL equal the row data when pwm <= Brightness and 0 otherwise, while RowSel stays asserted for the full SHOW phase.
REQ-023 Without SCAN_DIMMING_EN, the Brightness port and PWM logic SHALL be absent and ColData SHALL be driven for the full SHOW phase.

Verification (ROW_CYCLES = 8, BLANK_CYCLES = 2 unless stated)
REQ-024 Reset: hold RESET = 1 for 3 cycles with DisplayBuffer all ones -> RowSel = 0, ColData = 0, FrameStart = 0 throughout.
REQ-025 Scan order: DisplayBuffer row r = 16'h0001 << r; release reset -> FrameStart = 1 at cycle 1, blank at cycles 2-3, RowSel = ColData = 16'h0001 at cycles 4-11, RowSel = ColData = 16'h0002 at cycles 14-21, next FrameStart at cycle 162.
REQ-026 Tear-free: during row 3 SHOW, change DisplayBuffer to all ones -> rows 4-15 still show the old pattern; all ones first appears in the frame after the next FrameStart.
REQ-027 Wrap: after the last SHOW cycle of row 15, the next cycle has FrameStart = 1, RowSel = 0, and the following SHOW phase drives RowSel = 16'h0001.
REQ-028 Mid-frame reset: assert RESET for 1 cycle during row 7 SHOW -> outputs 0 at the next edge, then FrameStart = 1 and a restart from row 0 with the current DisplayBuffer.
REQ-029 Dimming (SCAN_DIMMING_EN, ROW_CYCLES = 16, Brightness = 3, all ones) -> in each SHOW, ColData = 16'hFFFF for the first 4 cycles and 0 for the remaining 12; RowSel is asserted for all 16 cycles.
